// File: rtl/trace_scheduler.sv
// trace_scheduler: line-ahead job sequencer for the row-level wall tracer.
// Launches one trace per visible row two lines before it is displayed,
// captures the tracer result, commits it to the row renderer at end of line,
// aborts and counts jobs that overrun their line, and marks a POV-safe window
// in vertical blanking while no trace is in flight.
module trace_scheduler #(
  parameter int unsigned V_VIEW = 480,
  parameter int unsigned V_MAX  = 524,
  parameter int unsigned SIZE_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_hmax,
  input  logic [9:0]        i_vpos,
  output logic              o_trace_start,
  output logic              o_trace_abort,
  output logic [9:0]        o_trace_row,
  input  logic              i_trace_done,
  input  logic              i_trace_side,
  input  logic [SIZE_W-1:0] i_trace_size,
  output logic              o_side,
  output logic [SIZE_W-1:0] o_size,
  output logic              o_busy,
  output logic              o_pov_latch,
  input  logic              i_clear_overrun,
  output logic              o_overrun,
  output logic [7:0]        o_overrun_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no job in flight
    ST_TRACE = 2'd1,  // job in flight, waiting for done
    ST_DONE  = 2'd2   // result held, waiting for end of line
  } state_e;

  localparam logic [10:0] VMAX_L  = 11'(V_MAX);
  localparam logic [10:0] VVIEW_L = 11'(V_VIEW);
  localparam logic [10:0] FRAME_L = 11'(V_MAX + 1);

  state_e              state_q, state_d;
  logic                hold_side_q, hold_side_d;
  logic [SIZE_W-1:0]   hold_size_q, hold_size_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic [9:0]          row_q, row_d;
  logic                side_q, side_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                busy_q, busy_d;
  logic                pov_q, pov_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          count_q, count_d;

  logic [10:0]         vpos_sat;
  logic [10:0]         target_raw;
  logic [10:0]         target;
  logic                sched_ok;
  logic                overrun_evt;

  // Line arithmetic: clamp out-of-range vpos, then pick the row two lines
  // ahead, wrapping across the frame boundary.
  always_comb begin
    vpos_sat   = ({1'b0, i_vpos} > VMAX_L) ? VMAX_L : {1'b0, i_vpos};
    target_raw = vpos_sat + 11'd2;
    target     = (target_raw > VMAX_L) ? (target_raw - FRAME_L) : target_raw;
  end

  // A new job is launched only for visible rows while enabled; a job still
  // tracing at end of line without a same-cycle done has overrun its budget.
  assign sched_ok    = i_enable && (target < VVIEW_L);
  assign overrun_evt = i_hmax && (state_q == ST_TRACE) && !i_trace_done;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    hold_side_d = hold_side_q;
    hold_size_d = hold_size_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    row_d       = row_q;
    side_d      = side_q;
    size_d      = size_q;
    pov_d       = 1'b0;
    overrun_d   = overrun_q;
    count_d     = count_q;

    if (i_hmax) begin
      // Commit the result for the line about to be displayed.
      unique case (state_q)
        ST_DONE: begin
          side_d = hold_side_q;
          size_d = hold_size_q;
        end
        ST_TRACE: begin
          if (i_trace_done) begin
            side_d = i_trace_side;
            size_d = i_trace_size;
          end else begin
            side_d = 1'b0;
            size_d = '0;
          end
        end
        default: begin
          side_d = 1'b0;
          size_d = '0;
        end
      endcase

      // Schedule the job for the row two lines ahead.
      if (sched_ok) begin
        row_d   = target[9:0];
        start_d = 1'b1;
        state_d = ST_TRACE;
      end else begin
        state_d = ST_IDLE;
      end

      // POV window opens after the last visible line once nothing is queued.
      pov_d = (vpos_sat == (VVIEW_L - 11'd1)) && !sched_ok;
    end else if ((state_q == ST_TRACE) && i_trace_done) begin
      // First done of the job is captured; later (level-held) dones are
      // ignored because the state has left TRACE.
      hold_side_d = i_trace_side;
      hold_size_d = i_trace_size;
      state_d     = ST_DONE;
    end

    // Overrun bookkeeping: a coincident clear loses to the new overrun.
    if (overrun_evt) begin
      abort_d   = 1'b1;
      overrun_d = 1'b1;
      if (i_clear_overrun) begin
        count_d = 8'd1;
      end else if (count_q != 8'hff) begin
        count_d = count_q + 8'd1;
      end
    end else if (i_clear_overrun) begin
      overrun_d = 1'b0;
      count_d   = 8'd0;
    end

    busy_d = (state_d == ST_TRACE);
  end

  // State and registered outputs; asynchronous reset returns to IDLE with all
  // outputs cleared and emits no abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      // NOTE: the holding register is reset as well, so a DONE commit can
      // never expose an unknown value even if the state were corrupted.
      hold_side_q <= 1'b0;
      hold_size_q <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      row_q       <= '0;
      side_q      <= 1'b0;
      size_q      <= '0;
      busy_q      <= 1'b0;
      pov_q       <= 1'b0;
      overrun_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed from the previous cycle, independent of statement order.
      state_q     <= state_d;
      hold_side_q <= hold_side_d;
      hold_size_q <= hold_size_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      row_q       <= row_d;
      side_q      <= side_d;
      size_q      <= size_d;
      busy_q      <= busy_d;
      pov_q       <= pov_d;
      overrun_q   <= overrun_d;
      count_q     <= count_d;
    end
  end

  assign o_trace_start   = start_q;
  assign o_trace_abort   = abort_q;
  assign o_trace_row     = row_q;
  assign o_side          = side_q;
  assign o_size          = size_q;
  assign o_busy          = busy_q;
  assign o_pov_latch     = pov_q;
  assign o_overrun       = overrun_q;
  assign o_overrun_count = count_q;

  // Structural invariants of the sequencer.
  a_start_busy : assert property (@(posedge clk) disable iff (reset)
    o_trace_start |-> o_busy);
  a_abort_flag : assert property (@(posedge clk) disable iff (reset)
    o_trace_abort |-> o_overrun);
  a_pov_idle   : assert property (@(posedge clk) disable iff (reset)
    o_pov_latch |-> !o_busy);
  a_flag_count : assert property (@(posedge clk) disable iff (reset)
    o_overrun == (o_overrun_count != 8'd0));
  a_busy_state : assert property (@(posedge clk) disable iff (reset)
    o_busy == (state_q == ST_TRACE));

endmodule

// File: tb/tb_trace_scheduler.sv
// tb_trace_scheduler: randomized bench for trace_scheduler with a reference
// model of the line-ahead scheduling rules, a per-cycle output compare, and
// literal expectations for the directed scenarios in each frame.
module tb_trace_scheduler;

  localparam int V_VIEW = 480;
  localparam int V_MAX  = 524;
  localparam int SIZE_W = 11;
  localparam int LINE   = 16;
  localparam int NEVER  = 100000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_enable, i_hmax, i_trace_done, i_trace_side, i_clear_overrun;
  logic [9:0]        i_vpos;
  logic [SIZE_W-1:0] i_trace_size;
  logic              o_trace_start, o_trace_abort, o_side, o_busy, o_pov_latch, o_overrun;
  logic [9:0]        o_trace_row;
  logic [SIZE_W-1:0] o_size;
  logic [7:0]        o_overrun_count;

  always #5 clk = ~clk;

  trace_scheduler #(.V_VIEW(V_VIEW), .V_MAX(V_MAX), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_hmax(i_hmax), .i_vpos(i_vpos),
    .o_trace_start(o_trace_start), .o_trace_abort(o_trace_abort), .o_trace_row(o_trace_row),
    .i_trace_done(i_trace_done), .i_trace_side(i_trace_side), .i_trace_size(i_trace_size),
    .o_side(o_side), .o_size(o_size), .o_busy(o_busy), .o_pov_latch(o_pov_latch),
    .i_clear_overrun(i_clear_overrun), .o_overrun(o_overrun), .o_overrun_count(o_overrun_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      if (bad >= 200) finish_run();
    end
  endtask

  // Position of the stimulus, for messages and per-line bookkeeping.
  int cur_frame = 0, cur_line = V_MAX - 2, cur_cyc = 0;

  // ---------------------------------------------------------------------
  // Reference model. A job is "live" from its launch until the next end of
  // line; its committed value is the first tracer result seen while live,
  // or 0 with an overrun if none arrived by that end of line.
  // ---------------------------------------------------------------------
  bit                job_live = 0, have_res = 0;
  logic              res_side = 0;
  logic [SIZE_W-1:0] res_size = '0;
  logic              e_start = 0, e_abort = 0, e_side = 0, e_busy = 0, e_pov = 0, e_ovf = 0;
  logic [9:0]        e_row = '0;
  logic [SIZE_W-1:0] e_size = '0;
  int                e_cnt = 0;

  always @(posedge clk or posedge reset) begin
    int v, t;
    if (reset) begin
      job_live = 0; have_res = 0;
      e_start = 0; e_abort = 0; e_row = '0; e_side = 0; e_size = '0;
      e_busy = 0; e_pov = 0; e_ovf = 0; e_cnt = 0;
    end else begin
      e_start = 0; e_abort = 0; e_pov = 0;
      if (job_live && !have_res && i_trace_done) begin
        have_res = 1; res_side = i_trace_side; res_size = i_trace_size;
      end
      if (i_hmax) begin
        v = (int'(i_vpos) > V_MAX) ? V_MAX : int'(i_vpos);
        e_side = have_res ? res_side : 1'b0;
        e_size = have_res ? res_size : '0;
        if (job_live && !have_res) begin
          e_abort = 1; e_ovf = 1;
          e_cnt = i_clear_overrun ? 1 : ((e_cnt >= 255) ? 255 : e_cnt + 1);
        end else if (i_clear_overrun) begin
          e_ovf = 0; e_cnt = 0;
        end
        t = (v + 2) % (V_MAX + 1);
        have_res = 0;
        job_live = i_enable && (t < V_VIEW);
        if (job_live) begin e_start = 1; e_row = 10'(t); end
        e_pov = (v == V_VIEW - 1) && !job_live;
      end else if (i_clear_overrun) begin
        e_ovf = 0; e_cnt = 0;
      end
      e_busy = job_live && !have_res;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    check($sformatf("outputs f%0d l%0d c%0d", cur_frame, cur_line, cur_cyc),
          {o_trace_start, o_trace_abort, o_trace_row, o_side, o_size, o_busy,
           o_pov_latch, o_overrun, o_overrun_count},
          {e_start, e_abort, e_row, e_side, e_size, e_busy, e_pov, e_ovf, 8'(e_cnt)});
  end

  // ---------------------------------------------------------------------
  // Observations for the literal expectations.
  // ---------------------------------------------------------------------
  int                starts [0:7] = '{default: 0};
  int                first_row [0:7] = '{default: -1};
  int                first_line [0:7] = '{default: -1};
  int                aborts [0:7] = '{default: 0};
  int                abort_line [0:7] = '{default: -1};
  int                pov_cnt [0:7] = '{default: 0};
  int                pov_line [0:7] = '{default: -1};
  int                pov_cyc [0:7] = '{default: -1};
  int                busy_win [0:7] = '{default: 0};
  logic [SIZE_W-1:0] size_seen [0:7][0:V_MAX];
  int                cnt_seen [0:7][0:V_MAX];
  logic              ovf_seen [0:7][0:V_MAX];

  always @(negedge clk) begin
    int sf;
    if (!reset) begin
      if (o_trace_start) begin
        sf = (int'(o_trace_row) < cur_line) ? cur_frame + 1 : cur_frame;
        starts[sf]++;
        if (first_row[sf] < 0) begin first_row[sf] = int'(o_trace_row); first_line[sf] = cur_line; end
      end
      if (o_trace_abort) begin
        aborts[cur_frame]++;
        if (abort_line[cur_frame] < 0) abort_line[cur_frame] = cur_line;
      end
      if (o_pov_latch) begin
        pov_cnt[cur_frame]++; pov_line[cur_frame] = cur_line; pov_cyc[cur_frame] = cur_cyc;
      end
      if (cur_line >= V_VIEW && cur_line < V_MAX && o_busy) busy_win[cur_frame]++;
      if (cur_cyc == LINE / 2) begin
        size_seen[cur_frame][cur_line] = o_size;
        cnt_seen[cur_frame][cur_line]  = int'(o_overrun_count);
        ovf_seen[cur_frame][cur_line]  = o_overrun;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Tracer stand-in and line timing.
  // ---------------------------------------------------------------------
  bit job_active = 0, job_hold = 0, holding = 0;
  int job_cnt = 0, job_row = 0;

  function automatic void plan(input int f, input int row, output int lat, output bit hold);
    hold = 0;
    lat  = int'($urandom_range(1, 10));
    case (f)
      2: if (row == 10) lat = NEVER;
         else if (row == 5) lat = LINE - 1;
         else if (row >= 20 && row <= 40) hold = 1;
      3: lat = NEVER;
      4: if (row == 3) lat = NEVER;
      5: begin
           lat  = int'($urandom_range(1, 20));
           if ($urandom_range(0, 99) < 15) lat = NEVER;
           hold = ($urandom_range(0, 99) < 30);
         end
      default: ;
    endcase
  endfunction

  task automatic step(input int f, input int l, input int c);
    int df;
    @(posedge clk);
    #1;
    cur_frame = f; cur_line = l; cur_cyc = c;
    if (o_trace_abort) begin job_active = 0; holding = 0; end
    if (o_trace_start) begin
      job_row = int'(o_trace_row);
      df = (job_row < l) ? f + 1 : f;
      plan(df, job_row, job_cnt, job_hold);
      job_active = 1; holding = 0;
    end
    i_trace_done = 0;
    i_trace_side = 1'($urandom_range(0, 1));
    i_trace_size = SIZE_W'($urandom);
    if (holding) begin
      i_trace_done = 1;
      i_trace_size = SIZE_W'(job_row) ^ {SIZE_W{1'b1}};
    end else if (job_active) begin
      if (job_cnt == 0) begin
        i_trace_done = 1;
        i_trace_size = SIZE_W'(job_row);
        job_active = 0;
        holding = job_hold;
      end else begin
        job_cnt--;
      end
    end
    i_hmax = (c == LINE - 1);
    if (c == 0) i_vpos = (f == 5 && l == V_MAX) ? 10'(525 + $urandom_range(0, 498)) : 10'(l);
    if (c == 0 && f == 2 && l == 200) i_enable = 0;
    if (c == 0 && f == 2 && l == 300) i_enable = 1;
    if (c == 0 && f == 5 && $urandom_range(0, 19) == 0) i_enable = ~i_enable;
    if (c == 0 && f == 6) i_enable = 1;
    i_clear_overrun = (f == 3 && l == 0 && c == 3) || (f == 4 && l == 2 && c == LINE - 1) ||
                      (f == 5 && $urandom_range(0, 199) == 0);
    if (f == 5 && l == 100 && c == 5) begin
      #1 reset = 1;
      #1 reset = 0;
    end
  endtask

  task automatic run_line(input int f, input int l);
    for (int c = 0; c < LINE; c++) step(f, l, c);
  endtask

  initial begin
    int n;
    i_enable = 1; i_hmax = 0; i_vpos = 10'(V_MAX - 2); i_trace_done = 0;
    i_trace_side = 0; i_trace_size = '0; i_clear_overrun = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_row", o_trace_row, 0);
    check("reset_count", o_overrun_count, 0);
    check("reset_misc", {o_trace_start, o_trace_abort, o_side, o_size, o_busy, o_pov_latch, o_overrun}, 0);
    reset = 0;

    for (int l = V_MAX - 2; l <= V_MAX; l++) run_line(0, l);
    for (int f = 1; f <= 5; f++)
      for (int l = 0; l <= V_MAX; l++) run_line(f, l);
    for (int l = 0; l < 6; l++) run_line(6, l);
    repeat (2) @(posedge clk);

    // Frame 1: undisturbed frame.
    check("f1_starts", starts[1], 480);
    check("f1_first_row", first_row[1], 0);
    check("f1_first_line", first_line[1], V_MAX);
    n = 0;
    for (int r = 0; r < V_VIEW; r++) if (size_seen[1][r] == SIZE_W'(r)) n++;
    check("f1_sizes_visible", n, 480);
    n = 0;
    for (int r = V_VIEW; r <= V_MAX; r++) if (size_seen[1][r] == '0) n++;
    check("f1_sizes_blank", n, 45);
    check("f1_overrun", ovf_seen[1][V_MAX], 0);

    // POV window in the two fully enabled frames.
    for (int f = 1; f <= 2; f++) begin
      check($sformatf("f%0d_pov_count", f), pov_cnt[f], 1);
      check($sformatf("f%0d_pov_when", f), {pov_line[f], pov_cyc[f]}, {32'(V_VIEW), 32'd0});
      check($sformatf("f%0d_busy_blank", f), busy_win[f], 0);
    end

    // Frame 2: missed row 10, done on hmax for row 5, held dones, enable gap.
    check("f2_aborts", aborts[2], 1);
    check("f2_abort_line", abort_line[2], 10);
    check("f2_row10", size_seen[2][10], 0);
    check("f2_row11", size_seen[2][11], 11);
    check("f2_row5", size_seen[2][5], 5);
    check("f2_count_before", cnt_seen[2][9], 0);
    check("f2_count_after", {ovf_seen[2][479], 8'(cnt_seen[2][479])}, {1'b1, 8'd1});
    n = 0;
    for (int r = 20; r <= 40; r++) if (size_seen[2][r] == SIZE_W'(r)) n++;
    check("f2_held_rows", n, 21);
    check("f2_row201", size_seen[2][201], 201);
    n = 0;
    for (int r = 202; r <= 301; r++) if (size_seen[2][r] == '0) n++;
    check("f2_disabled_rows", n, 100);
    check("f2_row302", size_seen[2][302], 302);
    check("f2_starts", starts[2], 380);

    // Frames 3 and 4: saturation and clear-versus-overrun.
    check("f3_saturated", {ovf_seen[3][479], 8'(cnt_seen[3][479])}, {1'b1, 8'd255});
    check("f4_still_sat", cnt_seen[4][2], 255);
    check("f4_clear_collide", {ovf_seen[4][3], 8'(cnt_seen[4][3]), size_seen[4][3]},
          {1'b1, 8'd1, 11'd0});

    finish_run();
  end

endmodule

// File: doc/trace_scheduler.md
Name: trace_scheduler

Overview:
- Line-ahead sequencer for the row-level wall tracer.
- Issues one trace job per visible row, one display line ahead of use. Captures each result and commits it to the row renderer at end of line. Aborts and flags jobs that overrun their line budget.
- Emits a safe-window pulse in vertical blanking so view vectors (POV) can be updated atomically while no trace is in flight.
- Sits between vga_sync and wall_tracer; replaces the free-running ~hmax run control.

Parameters:
- V_VIEW, 480, number of visible rows (rows 0..V_VIEW-1 are traced).
- V_MAX, 524, last vpos value of the frame (total lines - 1).
- SIZE_W, 11, width of traced wall size.

Ports:
- clk  in  1  system clock (pixel clock).
- reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  scheduler enable; sampled only on hmax cycles.
- i_hmax  in  1  high for exactly one cycle, the last cycle of each line.
- i_vpos  in  10  current line number, 0..V_MAX; stable during the hmax cycle.
- o_trace_start  out  1  one-cycle pulse launching a trace job.
- o_trace_abort  out  1  one-cycle pulse killing an unfinished job.
- o_trace_row  out  10  row the current or most recent job traces; held between jobs.
- i_trace_done  in  1  tracer result valid; pulse or level.
- i_trace_side  in  1  tracer side result; valid when i_trace_done.
- i_trace_size  in  SIZE_W  tracer size result; valid when i_trace_done.
- o_side  out  1  committed side for the current display line.
- o_size  out  SIZE_W  committed size for the current display line; 0 = no wall.
- o_busy  out  1  high while in TRACE.
- o_pov_latch  out  1  one-cycle pulse: POV may be updated this cycle.
- i_clear_overrun  in  1  clears o_overrun / o_overrun_count.
- o_overrun  out  1  sticky: at least one job overran.
- o_overrun_count  out  8  overrun counter; saturates at 255.

Behaviour:
- Reset (async): state IDLE; all outputs 0, including o_trace_row and o_overrun_count.
- States:
  - IDLE: no job in flight.
  - TRACE: job in flight, waiting for done.
  - DONE: result captured in a holding register; waiting for hmax.
- Capture:
  - In TRACE, first cycle with i_trace_done=1 captures side/size into the holding register → DONE.
  - i_trace_done is ignored in IDLE and DONE.
  - A level-held done never recaptures.
- Commit, on the hmax cycle of line L (registered; visible from the next cycle, i.e. line L+1):
  - DONE: o_side/o_size ← holding register.
  - TRACE with i_trace_done=1 the same cycle: commit i_trace_side/i_trace_size directly; not an overrun.
  - TRACE with no done: o_side←0, o_size←0, o_trace_abort pulses next cycle, o_overrun←1, count +1 (saturating).
  - IDLE: o_side←0, o_size←0.
- Schedule, same hmax cycle:
  - Target T = (L+2) mod (V_MAX+1).
  - If i_enable=1 and T<V_VIEW: o_trace_row←T, o_trace_start pulses next cycle, state→TRACE.
  - Otherwise state→IDLE.
  - When abort and start coincide, both pulse in the same cycle; the tracer treats abort first, then start.
- Pipeline: row R starts at end of line R-2, traces during line R-1, and is displayed during line R.
  - First start of a frame: hmax of line V_MAX-1 (row 0).
  - Last start: hmax of line V_VIEW-3.
- o_pov_latch:
  - Pulses the cycle after hmax of line V_VIEW-1.
  - Only when state is IDLE after that hmax; it always is under the legal V_VIEW ≤ V_MAX-2.
  - The next start cannot occur before line V_MAX-1, so POV is stable for every traced row.
- i_enable low:
  - Takes effect at the next hmax: the in-flight job is still committed or aborted normally, no new start, then IDLE.
  - Re-enable resumes at the next hmax whose target is visible.
- Overrun clear: i_clear_overrun zeroes the flag and count. If it coincides with an overrun event, the overrun wins: flag=1, count=1.
- Mid-frame reset: immediate IDLE with zero outputs; no abort pulse; resumes at the next qualifying hmax.
- i_vpos > V_MAX: treated as V_MAX.

Test Plan:
- Reset, then run a full frame with the tracer model answering done 100 cycles after start, size=i_trace_row:
  - exactly 480 starts.
  - first start after hmax of line 523 with row 0.
  - o_size during line R equals R for R=0..479.
  - 0 during lines 480..524; o_overrun stays 0.
- Tracer never answers for row 10:
  - o_trace_abort pulses after hmax of line 9.
  - o_size=0 during line 10; o_overrun=1, count=1.
  - row 11 is traced and displayed normally.
- Done asserted exactly on the hmax cycle for row 5: commits without overrun; o_size=5 in line 5. A held-level done in other rows causes no recapture.
- o_pov_latch:
  - exactly one pulse per frame, the cycle after hmax of line 479.
  - o_busy=0 from that point until the start at line 523.
- Deassert i_enable during line 200:
  - row 201 (already in flight) still displays.
  - rows ≥202 give o_size=0 and no starts.
  - re-enable at line 300: row 302 is displayed correctly.
- Force 300 overruns: count saturates at 255. Assert i_clear_overrun coincident with an overrun: flag=1, count=1.
